// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Width of the memory latency down-counter (latencies up to 256 cycles).
  localparam int LAT_CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and unified-memory port.
// master: the requesters plus the memory model; slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic             d_byte;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;

  logic             mem_en;
  logic             mem_we;
  logic             mem_byte;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_byte, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_byte, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// Priority decision between fetch and data with a saturating starvation
// counter that forces a fetch grant after STARVE_LIMIT data wins in a row.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   grant_en,
  input  logic   if_req,
  input  logic   d_req,
  output logic   if_gnt,
  output logic   d_gnt,
  output owner_t winner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_r;
  logic          force_if_s;

  // Pick the winner: data first unless fetch has been starved long enough.
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    winner     = OWN_D;
    force_if_s = if_req && (starve_r == SW'(STARVE_LIMIT));
    if (grant_en) begin
      if (force_if_s || (if_req && !d_req)) begin
        if_gnt = 1'b1;
        winner = OWN_IF;
      end else if (d_req) begin
        d_gnt  = 1'b1;
        winner = OWN_D;
      end else begin
        winner = OWN_D;
      end
    end else begin
      winner = OWN_D;
    end
  end

  // Count data grants that passed over a waiting fetch, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_r <= {SW{1'b0}};
    end else if (if_gnt) begin
      starve_r <= {SW{1'b0}};
    end else if (d_gnt) begin
      if (!if_req) begin
        starve_r <= {SW{1'b0}};
      end else if (starve_r != SW'(STARVE_LIMIT)) begin
        starve_r <= starve_r + SW'(1);
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= starve_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between instruction fetch and
// load/store. Each access runs IDLE/RESP -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_t           state_r;
  arb_state_t           state_s;
  owner_t               owner_r;
  owner_t               winner_s;
  logic                 if_gnt_s;
  logic                 d_gnt_s;
  logic                 any_gnt_s;
  logic                 grant_en_s;
  logic                 issue_s;
  logic                 done_s;
  logic                 cmd_we_r;
  logic                 cmd_byte_r;
  logic [WIDTH-1:0]     cmd_addr_r;
  logic [WIDTH-1:0]     cmd_wdata_r;
  logic [LAT_CNT_W-1:0] lat_cnt_r;
  logic [WIDTH-1:0]     if_rdata_r;
  logic [WIDTH-1:0]     d_rdata_r;

  // Grants are only offered between transactions and never while in reset.
  assign grant_en_s = reset && ((state_r == IDLE) || (state_r == RESP));
  assign any_gnt_s  = if_gnt_s || d_gnt_s;
  assign issue_s    = (state_r == ISSUE);
  assign done_s     = (state_r == WAIT) && (lat_cnt_r == {LAT_CNT_W{1'b0}});

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en_s),
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .if_gnt   (if_gnt_s),
    .d_gnt    (d_gnt_s),
    .winner   (winner_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, RESP: begin
        if (any_gnt_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (done_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Latch the winning command and its owner at grant time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_r     <= OWN_IF;
      cmd_we_r    <= 1'b0;
      cmd_byte_r  <= 1'b0;
      cmd_addr_r  <= {WIDTH{1'b0}};
      cmd_wdata_r <= {WIDTH{1'b0}};
    end else if (d_gnt_s) begin
      owner_r     <= winner_s;
      cmd_we_r    <= bus.d_we;
      cmd_byte_r  <= bus.d_byte;
      cmd_addr_r  <= bus.d_addr;
      cmd_wdata_r <= bus.d_wdata;
    end else if (if_gnt_s) begin
      owner_r     <= winner_s;
      cmd_we_r    <= 1'b0;
      cmd_byte_r  <= 1'b0;
      cmd_addr_r  <= bus.if_addr;
      cmd_wdata_r <= {WIDTH{1'b0}};
    end else begin
      owner_r     <= owner_r;
      cmd_we_r    <= cmd_we_r;
      cmd_byte_r  <= cmd_byte_r;
      cmd_addr_r  <= cmd_addr_r;
      cmd_wdata_r <= cmd_wdata_r;
    end
  end

  // Latency counter: loaded on issue so it reaches zero in the cycle the memory data is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_cnt_r <= {LAT_CNT_W{1'b0}};
    end else if (issue_s) begin
      lat_cnt_r <= LAT_CNT_W'(MEM_LATENCY - 1);
    end else if ((state_r == WAIT) && !done_s) begin
      lat_cnt_r <= lat_cnt_r - LAT_CNT_W'(1);
    end else begin
      lat_cnt_r <= lat_cnt_r;
    end
  end

  // Capture the response for the transaction owner; stores return zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rdata_r <= {WIDTH{1'b0}};
      d_rdata_r  <= {WIDTH{1'b0}};
    end else if (done_s && (owner_r == OWN_IF)) begin
      if_rdata_r <= bus.mem_rdata;
      d_rdata_r  <= d_rdata_r;
    end else if (done_s) begin
      if_rdata_r <= if_rdata_r;
      d_rdata_r  <= cmd_we_r ? {WIDTH{1'b0}} : bus.mem_rdata;
    end else begin
      if_rdata_r <= if_rdata_r;
      d_rdata_r  <= d_rdata_r;
    end
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.if_rvalid = (state_r == RESP) && (owner_r == OWN_IF);
  assign bus.d_rvalid  = (state_r == RESP) && (owner_r == OWN_D);
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_en    = issue_s;
  assign bus.mem_we    = issue_s && cmd_we_r;
  assign bus.mem_byte  = issue_s && cmd_byte_r;
  assign bus.mem_addr  = issue_s ? cmd_addr_r  : {WIDTH{1'b0}};
  assign bus.mem_wdata = issue_s ? cmd_wdata_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a one-cycle-latency memory model
// and per-requester response scoreboards.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];

  mem_port_arbiter_if #(.WIDTH(32)) bus ();

  mem_port_arbiter #(
    .WIDTH        (32),
    .MEM_LATENCY  (1),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: mem_val = 32'h2002_0005;
      32'h0000_0080: mem_val = 32'h0000_0007;
      default:       mem_val = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory model: data valid one cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem_val(bus.mem_addr);
    else            bus.mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic test_reset;
    logic [5:0] ctl;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ctl = {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.if_rvalid, bus.d_rvalid};
      checks++;
      if (ctl !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctl cycle %0d: got %b expected 000000", i, ctl);
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 128'd0) begin
        failures++;
        $display("FAIL reset_data cycle %0d: got addr=%h wdata=%h ifr=%h dr=%h expected 0",
                 i, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    reset      = 1'b1;
  endtask

  task automatic test_single_fetch;
    logic [31:0] exp;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_gnt: got if/d=%b expected 10", {bus.if_gnt, bus.d_gnt});
    end
    if_q.push_back(32'h2002_0005);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      failures++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h expected 1 0 00000040",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.if_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_wait: got en/rvalid=%b expected 00", {bus.mem_en, bus.if_rvalid});
    end
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_rvalid: got if/d=%b expected 10", {bus.if_rvalid, bus.d_rvalid});
    end
    exp = (if_q.size() > 0) ? if_q.pop_front() : 32'hX;
    checks++;
    if (bus.if_rdata !== exp) begin
      failures++;
      $display("FAIL fetch_rdata: got %h expected %h", bus.if_rdata, exp);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = 32'h80;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL simul_first_gnt: got if/d=%b expected 01", {bus.if_gnt, bus.d_gnt});
    end
    d_q.push_back(32'h7);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.d_rvalid} !== 2'b00) begin
        failures++;
        $display("FAIL simul_hold off=%0d: got ifgnt/drvalid=%b expected 00", k,
                 {bus.if_gnt, bus.d_rvalid});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.d_rvalid, bus.if_gnt} !== 2'b11) begin
      failures++;
      $display("FAIL simul_resp_gnt: got drvalid/ifgnt=%b expected 11", {bus.d_rvalid, bus.if_gnt});
    end
    exp = (d_q.size() > 0) ? d_q.pop_front() : 32'hX;
    checks++;
    if (bus.d_rdata !== exp) begin
      failures++;
      $display("FAIL simul_d_rdata: got %h expected %h", bus.d_rdata, exp);
    end
    if_q.push_back(mem_val(32'h100));
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL simul_if_issue: got en=%b addr=%h expected 1 00000100", bus.mem_en, bus.mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    exp = (if_q.size() > 0) ? if_q.pop_front() : 32'hX;
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata} !== {2'b10, exp}) begin
      failures++;
      $display("FAIL simul_if_resp: got if/d rvalid=%b rdata=%h expected 10 %h",
               {bus.if_rvalid, bus.d_rvalid}, bus.if_rdata, exp);
    end
  endtask

  task automatic test_store;
    int          en_cnt;
    logic [31:0] exp;
    en_cnt = 0;
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_byte  = 1'b0;
    bus.d_addr  = 32'h54;
    bus.d_wdata = 32'hABCD;
    #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL store_gnt: got %b expected 1", bus.d_gnt);
    end
    d_q.push_back(32'h0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      checks++;
      if (bus.mem_en && {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h54, 32'hABCD}) begin
        failures++;
        $display("FAIL store_cmd: got we=%b addr=%h wdata=%h expected 1 00000054 0000abcd",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end else if (!bus.mem_en && {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'd0) begin
        failures++;
        $display("FAIL store_idle_bus off=%0d: got we=%b addr=%h wdata=%h expected 0", k,
                 bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
    checks++;
    if (en_cnt !== 1) begin
      failures++;
      $display("FAIL store_en_count: got %0d expected 1", en_cnt);
    end
    exp = (d_q.size() > 0) ? d_q.pop_front() : 32'hX;
    checks++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.d_rdata} !== {2'b10, exp}) begin
      failures++;
      $display("FAIL store_resp: got d/if rvalid=%b rdata=%h expected 10 %h",
               {bus.d_rvalid, bus.if_rvalid}, bus.d_rdata, exp);
    end
  endtask

  task automatic test_starvation;
    int          g;
    int          last;
    logic        exp_if;
    logic [31:0] exp;
    g    = 0;
    last = 0;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h200;
    for (int c = 0; c < 100 && g < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.d_rvalid) begin
        exp = (d_q.size() > 0) ? d_q.pop_front() : 32'hX;
        checks++;
        if (bus.d_rdata !== exp) begin
          failures++;
          $display("FAIL starve_d_rdata: got %h expected %h", bus.d_rdata, exp);
        end
      end
      if (bus.if_rvalid) begin
        exp = (if_q.size() > 0) ? if_q.pop_front() : 32'hX;
        checks++;
        if (bus.if_rdata !== exp) begin
          failures++;
          $display("FAIL starve_if_rdata: got %h expected %h", bus.if_rdata, exp);
        end
      end
      if (bus.if_gnt || bus.d_gnt) begin
        exp_if = ((g % 5) == 4);
        checks++;
        if ({bus.if_gnt, bus.d_gnt} !== {exp_if, !exp_if}) begin
          failures++;
          $display("FAIL starve_order grant %0d: got if/d=%b expected %b", g,
                   {bus.if_gnt, bus.d_gnt}, {exp_if, !exp_if});
        end
        if (g > 0) begin
          checks++;
          if (cyc - last !== 3) begin
            failures++;
            $display("FAIL starve_spacing grant %0d: got %0d cycles expected 3", g, cyc - last);
          end
        end
        if (bus.if_gnt) if_q.push_back(mem_val(32'h300));
        else            d_q.push_back(mem_val(32'h200));
        last = cyc;
        g++;
      end
    end
    checks++;
    if (g !== 10) begin
      failures++;
      $display("FAIL starve_timeout: got %0d grants expected 10", g);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    for (int c = 0; c < 12 && (if_q.size() + d_q.size()) > 0; c++) begin
      @(negedge clk);
      if (bus.d_rvalid) begin
        exp = d_q.pop_front();
        checks++;
        if (bus.d_rdata !== exp) begin
          failures++;
          $display("FAIL starve_drain_d: got %h expected %h", bus.d_rdata, exp);
        end
      end
      if (bus.if_rvalid) begin
        exp = if_q.pop_front();
        checks++;
        if (bus.if_rdata !== exp) begin
          failures++;
          $display("FAIL starve_drain_if: got %h expected %h", bus.if_rdata, exp);
        end
      end
    end
    checks++;
    if ((if_q.size() + d_q.size()) !== 0) begin
      failures++;
      $display("FAIL starve_drain_left: got %0d pending expected 0", if_q.size() + d_q.size());
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] exp;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstwait_gnt: got %b expected 1", bus.if_gnt);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.if_rdata} !== 35'd0) begin
        failures++;
        $display("FAIL rstwait_abandon off=%0d: got ifv/dv/en=%b ifr=%h expected 0", k,
                 {bus.if_rvalid, bus.d_rvalid, bus.mem_en}, bus.if_rdata);
      end
      @(negedge clk);
    end
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h80;
    #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstwait_new_gnt: got %b expected 1", bus.d_gnt);
    end
    d_q.push_back(32'h7);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    exp = (d_q.size() > 0) ? d_q.pop_front() : 32'hX;
    checks++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL rstwait_new_resp: got rvalid=%b rdata=%h expected 1 %h",
               bus.d_rvalid, bus.d_rdata, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    reset        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_byte   = 1'b0;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_starvation();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
